// File: rtl/simon_pkg.sv
// Shared Simon Says definitions: direction codes, direction width and the
// direction_checker state encoding used by the display/LED decode.
package simon_pkg;

    localparam int DIR_W = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRIME      = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_WAIT_PRESS = 3'd3,
        ST_ADVANCE    = 3'd4,
        ST_WIN        = 3'd5,
        ST_LOSE       = 3'd6
    } dc_state_e;

endpackage

// File: rtl/press_timer.sv
// Down-counting window timer: clear loads TIMEOUT_CYCLES-1, enable counts down,
// expired flags the terminal count so the owner can act on the last cycle.
module press_timer
    import simon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/direction_checker.sv
// Simon Says game control: judges debounced presses against the shifter's
// expected move, pulses the shifter forward on a match, flags win or loss.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   IDLE        | no round since reset, waiting for start
//   PRIME       | shift_enable high, loads the first move
//   SETTLE      | one cycle for the registered shifter output; loads timer
//   WAIT_PRESS  | press window open, timer running
//   ADVANCE     | shift_enable high, steps to the next move
//   WIN         | round completed, win held until start
//   LOSE        | wrong press or timeout, lose held until start
module direction_checker
    import simon_pkg::*;
#(
    parameter int SEQ_LEN        = 3,
    parameter int DIR_W          = simon_pkg::DIR_W,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         press_valid,
    input  logic [DIR_W-1:0]             press_dir,
    input  logic [DIR_W-1:0]             correct_direction,
    output logic                         shift_enable,
    output logic [$clog2(SEQ_LEN+1)-1:0] step_count,
    output logic                         busy,
    output logic                         win,
    output logic                         lose
);

    localparam int CNT_W = $clog2(SEQ_LEN + 1);
    localparam logic [CNT_W-1:0] SEQ_MAX = CNT_W'(SEQ_LEN);

    dc_state_e        state;
    logic             timer_expired;
    logic [CNT_W-1:0] step_next;

    // Count never wraps even if SEQ_LEN fills the counter width.
    assign step_next = (step_count == SEQ_MAX) ? step_count : step_count + CNT_W'(1);

    press_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_press_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == ST_SETTLE),
        .enable (state == ST_WAIT_PRESS),
        .expired(timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            shift_enable <= 1'b0;
            step_count   <= '0;
            busy         <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            shift_enable <= 1'b0;
            case (state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        state        <= ST_PRIME;
                        shift_enable <= 1'b1;
                        step_count   <= '0;
                        busy         <= 1'b1;
                        win          <= 1'b0;
                        lose         <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state <= ST_WAIT_PRESS;
                end
                ST_WAIT_PRESS: begin
                    // A press on the final window cycle beats the timeout.
                    if (press_valid) begin
                        if (press_dir == correct_direction) begin
                            step_count <= step_next;
                            if (step_next == SEQ_MAX) begin
                                state <= ST_WIN;
                                busy  <= 1'b0;
                                win   <= 1'b1;
                            end else begin
                                state        <= ST_ADVANCE;
                                shift_enable <= 1'b1;
                            end
                        end else begin
                            state <= ST_LOSE;
                            busy  <= 1'b0;
                            lose  <= 1'b1;
                        end
                    end else if (timer_expired) begin
                        state <= ST_LOSE;
                        busy  <= 1'b0;
                        lose  <= 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    state <= ST_SETTLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_direction_checker.sv
// Directed bench for direction_checker with a 16-cycle press window.
module tb_direction_checker;
    import simon_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       press_valid = 1'b0;
    logic [1:0] press_dir = 2'b00;
    logic [1:0] correct_direction = 2'b00;
    logic       shift_enable;
    logic [1:0] step_count;
    logic       busy;
    logic       win;
    logic       lose;

    int tests  = 0;
    int failed = 0;
    int se_count = 0;

    direction_checker #(
        .SEQ_LEN       (3),
        .DIR_W         (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .press_valid      (press_valid),
        .press_dir        (press_dir),
        .correct_direction(correct_direction),
        .shift_enable     (shift_enable),
        .step_count       (step_count),
        .busy             (busy),
        .win              (win),
        .lose             (lose)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (shift_enable === 1'b1) se_count++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] d);
        press_valid = 1'b1;
        press_dir   = d;
        tick();
        press_valid = 1'b0;
    endtask

    initial begin
        // reset values
        ticks(2);
        reset = 1'b0;
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_se", 32'(shift_enable), 0);
        check("rst_step", 32'(step_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_win", 32'(win), 0);
        check("rst_lose", 32'(lose), 0);

        // full round LEFT, DOWN, RIGHT
        se_count = 0;
        correct_direction = 2'b10;
        pulse_start();
        check("prime_se", 32'(shift_enable), 1);
        check("prime_busy", 32'(busy), 1);
        tick();
        check("settle_se", 32'(shift_enable), 0);
        tick();
        press(2'b10);
        check("r1_step", 32'(step_count), 1);
        check("r1_se", 32'(shift_enable), 1);
        correct_direction = 2'b01;
        ticks(2);
        press(2'b01);
        check("r2_step", 32'(step_count), 2);
        check("r2_se", 32'(shift_enable), 1);
        correct_direction = 2'b11;
        ticks(2);
        press(2'b11);
        check("r3_step", 32'(step_count), 3);
        check("r3_win", 32'(win), 1);
        check("r3_busy", 32'(busy), 0);
        check("r3_se", 32'(shift_enable), 0);
        ticks(3);
        check("win_held", 32'(win), 1);
        check("round_pulses", 32'(se_count), 3);

        // restart from WIN, wrong press
        se_count = 0;
        correct_direction = 2'b00;
        pulse_start();
        check("rs_win_clr", 32'(win), 0);
        check("rs_se", 32'(shift_enable), 1);
        ticks(2);
        press(2'b01);
        check("wrong_lose", 32'(lose), 1);
        check("wrong_step", 32'(step_count), 0);
        check("wrong_busy", 32'(busy), 0);
        ticks(4);
        check("wrong_pulses", 32'(se_count), 1);

        // restart after loss, stray press in PRIME/SETTLE, stray start in WAIT_PRESS
        se_count = 0;
        pulse_start();
        check("rl_lose_clr", 32'(lose), 0);
        check("rl_se", 32'(shift_enable), 1);
        press_valid = 1'b1;
        press_dir   = 2'b00;
        ticks(2);
        press_valid = 1'b0;
        check("ign_press_step", 32'(step_count), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start_busy", 32'(busy), 1);
        check("ign_start_se", 32'(shift_enable), 0);
        check("ign_step", 32'(step_count), 0);
        check("ign_pulses", 32'(se_count), 1);
        press(2'b00);
        check("ign_next_step", 32'(step_count), 1);
        correct_direction = 2'b01;
        ticks(2);
        press(2'b01);
        check("mid_step", 32'(step_count), 2);
        ticks(2);

        // reset in WAIT_PRESS with step_count = 2
        check("pre_rst_state", 32'(dut.state), 32'(ST_WAIT_PRESS));
        se_count = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_state", 32'(dut.state), 32'(ST_IDLE));
        check("mrst_step", 32'(step_count), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_se", 32'(shift_enable), 0);
        check("mrst_win", 32'(win), 0);
        check("mrst_lose", 32'(lose), 0);
        ticks(3);
        check("mrst_pulses", 32'(se_count), 0);

        // clean round after reset
        correct_direction = 2'b11;
        pulse_start();
        ticks(2);
        press(2'b11);
        correct_direction = 2'b00;
        ticks(2);
        press(2'b00);
        correct_direction = 2'b10;
        ticks(2);
        press(2'b10);
        check("clean_win", 32'(win), 1);
        check("clean_step", 32'(step_count), 3);
        check("clean_pulses", 32'(se_count), 3);

        // timeout after 16 idle window cycles
        correct_direction = 2'b00;
        pulse_start();
        ticks(2);
        ticks(15);
        check("to15_lose", 32'(lose), 0);
        check("to15_busy", 32'(busy), 1);
        tick();
        check("to16_lose", 32'(lose), 1);
        check("to16_busy", 32'(busy), 0);

        // press on the 15th window cycle is accepted
        pulse_start();
        ticks(2);
        ticks(14);
        press(2'b00);
        check("late15_step", 32'(step_count), 1);
        check("late15_lose", 32'(lose), 0);
        check("late15_se", 32'(shift_enable), 1);

        // press coinciding with timeout is judged normally
        ticks(2);
        ticks(15);
        press(2'b00);
        check("late16_step", 32'(step_count), 2);
        check("late16_lose", 32'(lose), 0);
        check("late16_busy", 32'(busy), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
